// File: rtl/ifm_pkg.sv
// Shared types and helpers for the ingress frame FIFO: write FSM encoding,
// wrap-aware pointer distance and saturating counter increment.
package ifm_pkg;

  typedef enum logic [1:0] {
    IFM_WR_IDLE = 2'd0,
    IFM_WR_RECV = 2'd1,
    IFM_WR_DROP = 2'd2
  } ifm_wr_state_e;

  localparam int IFM_MAX_W = 64;

  // Distance a - b for pointers that wrap at 2**ptr_w.
  function automatic logic [IFM_MAX_W-1:0] ifm_ptr_dist(
    input logic [IFM_MAX_W-1:0] a,
    input logic [IFM_MAX_W-1:0] b,
    input int unsigned          ptr_w
  );
    logic [IFM_MAX_W-1:0] mask;
    mask = (IFM_MAX_W'(1) << ptr_w) - IFM_MAX_W'(1);
    return (a - b) & mask;
  endfunction

  // Increment a w-bit counter, sticking at all-ones.
  function automatic logic [IFM_MAX_W-1:0] ifm_sat_inc(
    input logic [IFM_MAX_W-1:0] v,
    input int unsigned          w
  );
    logic [IFM_MAX_W-1:0] max_v;
    max_v = (w >= IFM_MAX_W) ? '1 : (IFM_MAX_W'(1) << w) - IFM_MAX_W'(1);
    return (v == max_v) ? v : v + IFM_MAX_W'(1);
  endfunction

endpackage

// File: rtl/ifm_frame_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module ifm_frame_ram #(
  parameter int WIDTH      = 73,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ifm_frame_fifo.sv
// Store-and-forward ingress frame FIFO: only complete good frames reach the
// reader; bad and overflowing frames are rolled back and counted.
module ifm_frame_fifo
  import ifm_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int AFULL_THRESH = 768,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  input  logic                  s_status_good,
  output logic                  s_afull,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  stat_good,
  output logic [CNT_WIDTH-1:0]  stat_bad,
  output logic [CNT_WIDTH-1:0]  stat_ovf
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int RAM_W = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t          wr_ptr_reg, cm_ptr_reg, cm_vis_reg, rd_ptr_reg;
  ifm_wr_state_e wr_state_reg;
  logic          afull_reg, m_valid_reg;
  logic [CNT_WIDTH-1:0] cnt_reg [3];

  ptr_t             occ;
  logic             full, wr_en, rd_en;
  logic             good_inc, bad_inc, ovf_inc;
  logic [2:0]       cnt_inc;
  logic [RAM_W-1:0] rd_data;

  assign occ  = PTR_W'(ifm_ptr_dist(IFM_MAX_W'(wr_ptr_reg), IFM_MAX_W'(rd_ptr_reg), PTR_W));
  assign full = (occ == PTR_W'(DEPTH));

  always_comb begin
    wr_en    = 1'b0;
    good_inc = 1'b0;
    bad_inc  = 1'b0;
    ovf_inc  = 1'b0;
    if (s_tvalid) begin
      if (wr_state_reg == IFM_WR_DROP || full) begin
        ovf_inc = s_tlast;
      end else begin
        wr_en    = 1'b1;
        good_inc = s_tlast & s_status_good;
        bad_inc  = s_tlast & ~s_status_good;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_state_reg <= IFM_WR_IDLE;
      wr_ptr_reg   <= '0;
      cm_ptr_reg   <= '0;
    end else if (s_tvalid) begin
      if (wr_state_reg == IFM_WR_DROP) begin
        if (s_tlast) wr_state_reg <= IFM_WR_IDLE;
      end else if (full) begin
        wr_ptr_reg   <= cm_ptr_reg;
        wr_state_reg <= s_tlast ? IFM_WR_IDLE : IFM_WR_DROP;
      end else if (s_tlast) begin
        wr_state_reg <= IFM_WR_IDLE;
        if (s_status_good) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          cm_ptr_reg <= wr_ptr_reg + PTR_ONE;
        end else begin
          wr_ptr_reg <= cm_ptr_reg;
        end
      end else begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
        wr_state_reg <= IFM_WR_RECV;
      end
    end
  end

  // The reader sees commits one cycle late so a freshly written entry is never
  // read in the same cycle it is written (no RAM collision semantics needed).
  assign rd_en = (!m_valid_reg || m_tready) && (rd_ptr_reg != cm_vis_reg);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cm_vis_reg  <= '0;
      rd_ptr_reg  <= '0;
      m_valid_reg <= 1'b0;
      afull_reg   <= 1'b0;
    end else begin
      cm_vis_reg <= cm_ptr_reg;
      afull_reg  <= (32'(occ) >= 32'(AFULL_THRESH));
      if (rd_en) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
        m_valid_reg <= 1'b1;
      end else if (m_tready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign cnt_inc = {ovf_inc, bad_inc, good_inc};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stat_clr)
          cnt_reg[i] <= '0;
        else if (cnt_inc[i])
          cnt_reg[i] <= CNT_WIDTH'(ifm_sat_inc(IFM_MAX_W'(cnt_reg[i]), CNT_WIDTH));
      end
    end
  end

  ifm_frame_ram #(
    .WIDTH      (RAM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data ({s_tdata, s_tkeep, s_tlast}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  // The RAM read register doubles as the output stage; mask it while empty.
  assign {m_tdata, m_tkeep, m_tlast} = rd_data & {RAM_W{m_valid_reg}};
  assign m_tvalid  = m_valid_reg;
  assign s_afull   = afull_reg;
  assign stat_good = cnt_reg[0];
  assign stat_bad  = cnt_reg[1];
  assign stat_ovf  = cnt_reg[2];

endmodule

// File: doc/ifm_frame_fifo.md
Name: ifm_frame_fifo

Overview:
- Parametrised, single-clock store-and-forward ingress frame FIFO.
- Sits between the MAC receive path and the DMA/AXI-stream consumer, replacing the separate data/good FIFO pair.
- Accepts a non-stallable beat stream with a per-frame good/bad status on the last beat. Only complete good frames are released to the reader.
- Bad frames and frames that overflow are rolled back in place, and each drop reason is counted.

Parameters:
- DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ADDR_WIDTH, 10, log2 of entry depth; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, 768, occupancy (entries, committed plus speculative) at or above which s_afull asserts.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- sys_clk  in  1  single clock for both sides.
- sys_rst_n  in  1  asynchronous active-low reset.
- s_tdata  in  DATA_WIDTH  ingress beat data.
- s_tkeep  in  KEEP_WIDTH  ingress byte enables.
- s_tlast  in  1  last beat of frame.
- s_tvalid  in  1  beat valid; there is no tready because ingress cannot stall.
- s_status_good  in  1  frame good (FCS/length ok); sampled only on the tlast beat.
- s_afull  out  1  registered almost-full flag.
- m_tdata  out  DATA_WIDTH  egress data.
- m_tkeep  out  KEEP_WIDTH  egress byte enables.
- m_tlast  out  1  egress last beat.
- m_tvalid  out  1  egress valid.
- m_tready  in  1  egress ready.
- stat_clr  in  1  synchronous clear of all statistics counters.
- stat_good  out  CNT_WIDTH  committed frames.
- stat_bad  out  CNT_WIDTH  frames dropped due to bad status.
- stat_ovf  out  CNT_WIDTH  frames dropped due to overflow.

Behaviour:
- Reset: sys_clk is the only clock; sys_rst_n is asynchronous, active-low.
  - All pointers, state, counters, s_afull, m_tvalid, m_tdata, m_tkeep and m_tlast clear to 0 immediately on assertion.
  - A partial frame in progress at reset is discarded.
- Storage: DEPTH x (DATA_WIDTH+KEEP_WIDTH+1) RAM with a 1-cycle read.
- Pointers are ADDR_WIDTH+1 bits, where the MSB is the wrap bit:
  - wr_ptr is speculative;
  - cm_ptr is committed;
  - rd_ptr is the RAM read pointer.
  - All arithmetic is modulo 2**(ADDR_WIDTH+1).
- full = (wr_ptr - rd_ptr) == DEPTH, evaluated with current register values (conservative).
- Write FSM states: IDLE, RECV, DROP.
  - IDLE/RECV, beat accepted and not full: write RAM[wr_ptr], wr_ptr+1, state RECV.
  - IDLE/RECV, beat accepted and full: wr_ptr <= cm_ptr.
    - If tlast: stat_ovf+1, state IDLE.
    - Otherwise: state DROP.
  - Tlast beat written with s_status_good=1: cm_ptr <= wr_ptr+1, stat_good+1, state IDLE.
  - Tlast beat written with s_status_good=0: wr_ptr <= cm_ptr, stat_bad+1, state IDLE.
  - DROP: discard beats. On tlast, stat_ovf+1 and go to IDLE. s_status_good is ignored.
  - A single-beat frame (tlast in IDLE) follows the same rules.
- Read side (FWFT, 1-entry output register):
  - When the output register is empty, or being consumed (m_tvalid & m_tready), and rd_ptr != cm_ptr: issue a RAM read and rd_ptr+1. The output register loads on the next edge.
  - Back-to-back reads sustain 1 beat/cycle when m_tready stays high.
  - Latency: tlast of a good frame sampled at edge E0; m_tvalid high after edge E2.
  - m_t* are held stable while m_tvalid & !m_tready.
  - Rollback never touches rd_ptr or cm_ptr, so the reader never sees uncommitted data.
- s_afull = registered (wr_ptr - rd_ptr) >= AFULL_THRESH.
- Counters saturate at all-ones.
  - stat_clr has priority over an increment in the same cycle.
  - A simultaneous good and ovf increment is impossible by construction.
- Simultaneous write and read in the same cycle is legal. The full check uses pre-update rd_ptr, so a beat may be dropped one cycle early; this is accepted.

Decomposition:
- Package ifm_pkg holds:
  - write FSM state encoding (IFM_WR_IDLE/RECV/DROP);
  - the pointer-distance function;
  - the saturating-increment function.
- One sub-module, ifm_frame_ram: simple dual-port RAM, one write port and one registered read port, parameterised by width and ADDR_WIDTH; inferable as BRAM.

Test Plan:
- Good frames: three good frames of 1, 4 and 9 beats, m_tready=1.
  - Expect 14 egress beats in order with m_tlast on beats 1, 5 and 14.
  - stat_good=3; first m_tvalid 2 cycles after the 1-beat frame's tlast.
- Bad frame rollback: a 5-beat frame with s_status_good=0 on tlast, then a 3-beat good frame.
  - Only 3 beats egress; stat_bad=1, stat_good=1; wr_ptr restored to the value before the bad frame.
- Overflow drop: ADDR_WIDTH=4, m_tready=0, a 20-beat good frame.
  - FSM enters DROP on beat 17; stat_ovf=1; no m_tvalid.
  - A following 2-beat good frame is accepted and egresses once m_tready=1.
- Wrap-around: ADDR_WIDTH=4, 100 random good frames of 1-6 beats with random m_tready.
  - Scoreboard shows an exact data/keep/last match.
  - s_afull tracks occupancy >= AFULL_THRESH (set AFULL_THRESH=12).
- Reset mid-frame: sys_rst_n low during beat 3 of a 6-beat frame with 2 committed beats pending.
  - m_tvalid=0 and all counters=0 immediately; after release a new good frame passes intact.
- Counter saturation and clear: CNT_WIDTH=2, 5 bad frames.
  - stat_bad stays at 3; stat_clr pulsed on the same cycle as a bad tlast gives stat_bad=0.
